// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem request FSM, IF/ID register
// Skid buffer absorbs a response arriving under stall; DROP waits out a response orphaned by a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_vld_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        instr_vld_o
);

    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] pend_pc;
    logic [31:0] buf_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_vld;
    logic        run;
    logic [31:0] redir_pc;
    logic        kill;

    assign redir_pc = redirect_pc_i & ~32'h0000_0003;
    assign kill     = redirect_i | flush_i;

    // run keeps the request low for the first cycle after reset release
    assign imem_req_o  = run && (state != HOLD);
    assign imem_addr_o = pc_q;
    assign instr_o     = ifid_vld ? ifid_instr : NOP_INSTR;
    assign pc_o        = ifid_pc;
    assign pc4_o       = ifid_pc + 32'd4;
    assign instr_vld_o = ifid_vld;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= FETCH;
            pc_q       <= RESET_PC;
            pend_pc    <= 32'h0;
            buf_instr  <= 32'h0;
            ifid_instr <= NOP_INSTR;
            ifid_pc    <= 32'h0;
            ifid_vld   <= 1'b0;
            run        <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            // decode consumes IF/ID whenever not stalled; a capture below re-validates it
            if (kill || !stall_i) begin
                ifid_vld <= 1'b0;
            end
            case (state)
                FETCH: begin
                    if (redirect_i) begin
                        if (imem_vld_i) begin
                            pc_q <= redir_pc;
                        end else begin
                            pend_pc <= redir_pc;
                            state   <= DROP;
                        end
                    end else if (imem_vld_i) begin
                        if (stall_i) begin
                            buf_instr <= imem_rdata_i;
                            state     <= HOLD;
                        end else begin
                            pc_q <= pc_q + 32'd4;
                            if (!flush_i) begin
                                ifid_instr <= imem_rdata_i;
                                ifid_pc    <= pc_q;
                                ifid_vld   <= 1'b1;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (redirect_i) begin
                        pc_q  <= redir_pc;
                        state <= FETCH;
                    end else if (!stall_i) begin
                        pc_q  <= pc_q + 32'd4;
                        state <= FETCH;
                        if (!flush_i) begin
                            ifid_instr <= buf_instr;
                            ifid_pc    <= pc_q;
                            ifid_vld   <= 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (imem_vld_i) begin
                        pc_q  <= redirect_i ? redir_pc : pend_pc;
                        state <= FETCH;
                    end else if (redirect_i) begin
                        pend_pc <= redir_pc;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_vld;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        instr_vld;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .redirect_i(redirect), .redirect_pc_i(rpc),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_rdata_i(imem_rdata), .imem_vld_i(imem_vld),
        .instr_o(instr), .pc_o(pc), .pc4_o(pc4), .instr_vld_o(instr_vld)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    // memory: answers a request after 'lat' waiting cycles (0 = same cycle)
    logic [1:0] lat;
    logic [1:0] wait_cnt;
    logic [1:0] fixed_lat = 2'd0;
    logic       rand_lat = 1'b0;

    assign imem_vld   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_vld ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= 2'd0;
            lat      <= fixed_lat;
        end else if (imem_req) begin
            if (imem_vld) begin
                wait_cnt <= 2'd0;
                lat      <= rand_lat ? 2'($urandom_range(0, 2)) : fixed_lat;
            end else begin
                wait_cnt <= wait_cnt + 2'd1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_b({tag, "_req"}, imem_req, 1'b0);
        check_b({tag, "_vld"}, instr_vld, 1'b0);
        check({tag, "_instr"}, instr, NOP);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_pc4"}, pc4, 32'h4);
        check({tag, "_addr"}, imem_addr, 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; rpc = 32'h0;
        step();
        step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();
        check_b("start_req", imem_req, 1'b1);
        check("start_addr", imem_addr, 32'h0);
    endtask

    typedef struct {
        logic        s, f, r;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic s, input logic f, input logic r, input logic [31:0] a,
                                input logic ev, input logic [31:0] epc, input logic ereq,
                                input logic [31:0] eaddr);
        vec_t v;
        v.s = s; v.f = f; v.r = r; v.rpc = a; v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        got;
        logic [31:0] exp_pc;
        logic        resync;
        int          deliveries;
        logic [31:0] p_instr, p_pc, p_addr;
        logic        p_req, p_mvld;
        logic        s, f, r;

        // zero-wait memory: stream, stall/HOLD, redirects, flush, wrap
        tbl[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h4);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 32'h8);
        tbl[2]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h8);
        tbl[3]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h8);
        tbl[4]  = mk(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b0, 32'h8);
        tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 32'hC);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 32'h10);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 32'h100,       1'b0, 32'hC,         1'b1, 32'h100);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h100,       1'b1, 32'h104);
        tbl[9]  = mk(1'b1, 1'b1, 1'b1, 32'h41,        1'b0, 32'h100,       1'b1, 32'h40);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h40,        1'b1, 32'h44);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h40,        1'b1, 32'h48);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h48,        1'b1, 32'h4C);
        tbl[13] = mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h48,        1'b1, 32'hFFFF_FFFC);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 32'h4);

        fixed_lat = 2'd0;
        rand_lat  = 1'b0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            stall = tbl[i].s; flush = tbl[i].f; redirect = tbl[i].r; rpc = tbl[i].rpc;
            step();
            stall = 1'b0; flush = 1'b0; redirect = 1'b0;
            check_b($sformatf("row%0d_vld", i), instr_vld, tbl[i].ev);
            check($sformatf("row%0d_pc", i), pc, tbl[i].epc);
            check($sformatf("row%0d_pc4", i), pc4, tbl[i].epc + 32'd4);
            check($sformatf("row%0d_instr", i), instr, tbl[i].ev ? mem_word(tbl[i].epc) : NOP);
            check_b($sformatf("row%0d_req", i), imem_req, tbl[i].ereq);
            check($sformatf("row%0d_addr", i), imem_addr, tbl[i].eaddr);
        end

        // two-cycle memory: redirect while a request is outstanding goes through DROP
        fixed_lat = 2'd2;
        do_reset();
        redirect = 1'b1; rpc = 32'h10;
        step();
        redirect = 1'b0;
        step();
        step();
        check("drop0_addr", imem_addr, 32'h10);
        step();
        check("req10_addr", imem_addr, 32'h10);
        redirect = 1'b1; rpc = 32'h100;
        step();
        redirect = 1'b0;
        check("drop_addr_held", imem_addr, 32'h10);
        check_b("drop_req", imem_req, 1'b1);
        check_b("drop_vld", instr_vld, 1'b0);
        step();
        check("drop_next_addr", imem_addr, 32'h100);
        check_b("drop_gap_vld", instr_vld, 1'b0);
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step();
            if (instr_vld) got = 1'b1;
        end
        check_b("drop_deliver", got, 1'b1);
        check("drop_deliver_pc", pc, 32'h100);
        check("drop_deliver_instr", instr, mem_word(32'h100));

        // reset asserted while HOLD has a buffered word and IF/ID is valid
        fixed_lat = 2'd0;
        do_reset();
        step();
        step();
        check("prehold_pc", pc, 32'h4);
        stall = 1'b1;
        step();
        check_b("hold_req", imem_req, 1'b0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midhold_rst");
        step();
        stall = 1'b0;
        rst_n = 1'b1;
        step();
        check_b("rehold_req", imem_req, 1'b1);
        check("rehold_addr", imem_addr, 32'h0);
        step();
        check_b("rehold_vld", instr_vld, 1'b1);
        check("rehold_pc", pc, 32'h0);
        check("rehold_instr", instr, mem_word(32'h0));

        // random traffic against a program-order model
        fixed_lat = 2'd1;
        rand_lat  = 1'b1;
        do_reset();
        exp_pc = 32'h0;
        resync = 1'b0;
        deliveries = 0;
        for (int n = 0; n < 2000; n++) begin
            p_instr = instr; p_pc = pc; p_req = imem_req; p_addr = imem_addr; p_mvld = imem_vld;
            s = ($urandom % 4) == 0;
            r = ($urandom % 20) == 0;
            f = ($urandom % 25) == 0;
            stall = s; redirect = r; flush = f;
            rpc = ($urandom % 2) ? $urandom : ($urandom & 32'h0000_03FF);
            step();
            stall = 1'b0; redirect = 1'b0; flush = 1'b0;
            check("rnd_addr_align", {30'h0, imem_addr[1:0]}, 32'h0);
            if (p_req && !p_mvld) begin
                check("rnd_addr_hold", imem_addr, p_addr);
                check_b("rnd_req_hold", imem_req, 1'b1);
            end
            if (r || f) begin
                check_b("rnd_kill_vld", instr_vld, 1'b0);
                check("rnd_kill_instr", instr, NOP);
                check("rnd_kill_pc", pc, p_pc);
                if (r) begin
                    exp_pc = rpc & ~32'h3;
                    resync = 1'b0;
                end else begin
                    resync = 1'b1;
                end
            end else if (s) begin
                check("rnd_stall_instr", instr, p_instr);
                check("rnd_stall_pc", pc, p_pc);
            end else if (instr_vld) begin
                if (!resync) check("rnd_pc", pc, exp_pc);
                check("rnd_instr", instr, mem_word(pc));
                check("rnd_pc4", pc4, pc + 32'd4);
                exp_pc = pc + 32'd4;
                resync = 1'b0;
                deliveries++;
            end else begin
                check("rnd_bubble_instr", instr, NOP);
                check("rnd_bubble_pc", pc, p_pc);
            end
        end
        check_b("rnd_progress", deliveries >= 200, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: NOP_INSTR, 32'h0000_0013, instruction presented when IF/ID is empty (addi x0,x0,0).
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 stall_i  in  1  hazard hold: IF/ID and PC frozen.
REQ-006 flush_i  in  1  invalidate IF/ID contents.
REQ-007 redirect_i  in  1  taken branch/jump; fetch restarts at redirect_pc_i.
REQ-008 redirect_pc_i  in  32  redirect target.
REQ-009 imem_req_o  out  1  instruction memory request.
REQ-010 imem_addr_o  out  32  request address, word aligned.
REQ-011 imem_rdata_i  in  32  returned instruction word.
REQ-012 imem_vld_i  in  1  response valid, 0..N cycles after request.
REQ-013 instr_o  out  32  IF/ID instruction, drives control-unit decode input.
REQ-014 pc_o  out  32  IF/ID PC of instr_o.
REQ-015 pc4_o  out  32  pc_o + 4, for PC+4 writeback select.
REQ-016 instr_vld_o  out  1  IF/ID holds a real instruction.

Function
REQ-017 Registers: pc_q (fetch PC), pend_pc (deferred redirect), buf_instr (skid), IF/ID {instr, pc, vld}, FSM state.
REQ-018 FSM states: FETCH, HOLD, DROP; encoding free.
REQ-019 imem_req_o = 1 in FETCH and DROP, 0 in HOLD; imem_addr_o = pc_q, stable from request until imem_vld_i seen.
REQ-020 FETCH, imem_vld_i=1, no redirect/flush, stall_i=0: IF/ID <= {imem_rdata_i, pc_q, 1}; pc_q <= pc_q+4; stay FETCH.
REQ-021 FETCH, imem_vld_i=1, stall_i=1, no redirect/flush: buf_instr <= imem_rdata_i; go HOLD; IF/ID unchanged.
REQ-022 HOLD, stall_i=0, no redirect/flush: IF/ID <= {buf_instr, pc_q, 1}; pc_q <= pc_q+4; go FETCH.
REQ-023 FETCH, redirect_i=1 with imem_vld_i=1: response discarded; pc_q <= redirect_pc_i; stay FETCH.
REQ-024 FETCH, redirect_i=1 with imem_vld_i=0: pend_pc <= redirect_pc_i; go DROP; pc_q unchanged (address held stable).
REQ-025 DROP: new redirect_i overwrites pend_pc; on imem_vld_i response discarded, pc_q <= pend_pc (or redirect_pc_i if redirect_i same cycle), go FETCH.
REQ-026 HOLD, redirect_i=1: buf_instr discarded; pc_q <= redirect_pc_i; go FETCH.
REQ-027 redirect_i or flush_i: IF/ID vld <= 0 at next edge, priority over stall_i and over any capture that cycle.
REQ-028 flush_i without redirect_i: in FETCH a same-cycle response is still captured per REQ-020/021 into pc_q/buf, but not into IF/ID; pc_q advance unaffected by flush.
REQ-029 stall_i=1, no flush/redirect: IF/ID and pc_q hold; FETCH without response keeps requesting.
REQ-030 redirect_pc_i[1:0] ignored; pc_q[1:0] always 0.
REQ-031 pc_q+4 and pc4_o wrap modulo 2^32 (32'hFFFF_FFFC -> 0).
REQ-032 instr_o = NOP_INSTR whenever IF/ID vld = 0; pc_o/pc4_o hold last values.
REQ-033 Latency: imem_vld_i at edge n -> instr_o valid after edge n (one cycle through IF/ID).

Reset
REQ-034 While i_rst_n=0: pc_q=RESET_PC, state FETCH, IF/ID vld=0, instr_o=NOP_INSTR, pc_o=0, pc4_o=4, pend_pc=0, buf_instr=0, imem_req_o=0.
REQ-035 First rising edge after release: imem_req_o=1, imem_addr_o=RESET_PC.
REQ-036 Reset mid-DROP/HOLD: outstanding response and buffer discarded; any imem_vld_i in first cycle after release ignored unless requested.

Verification
REQ-037 Zero-wait memory, 4 instructions, no stall -> instr_o sequence at pc_o 0,4,8,12 on consecutive cycles, instr_vld_o=1 from cycle 2.
REQ-038 stall_i high 3 cycles while response at PC 8 arrives -> HOLD, instr_o stays PC 4 word; after release PC 8 word appears next cycle, no loss/duplication.
REQ-039 2-cycle-latency memory, redirect_i to 0x100 one cycle after request at 0x10 -> DROP, imem_addr_o stays 0x10 until vld, response dropped, next request 0x100, instr_vld_o=0 in between.
REQ-040 redirect_i and flush_i with stall_i=1 -> instr_vld_o=0, instr_o=0x00000013 next cycle.
REQ-041 redirect_pc_i=0xFFFF_FFFE -> imem_addr_o=0xFFFF_FFFC; following fetch address 0x0000_0000.
REQ-042 i_rst_n asserted mid-HOLD -> outputs immediately at REQ-034 values; restart fetch at RESET_PC.
